// File: rtl/pcc_enc_pkg.sv
// pcc_enc_pkg: shared sizes, encoder state enum and popcount width helper for the pcc vote encoder.
package pcc_enc_pkg;
  localparam int N_POS_D  = 2;
  localparam int N_NEG_D  = 6;
  localparam int FEAT_W_D = 8;
  localparam int N_TOT    = N_POS_D + N_NEG_D;
  localparam int IDX_W    = $clog2(N_TOT);
  typedef enum logic {COLLECT, HOLD} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pcc_popcount.sv
// pcc_popcount: combinational count of set bits in a W-bit vector.
module pcc_popcount
  import pcc_enc_pkg::*;
#(
  parameter int W = 2,
  localparam int CW = cnt_w(W)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(bits[i]);
  end
endmodule

// File: rtl/pcc_vote_encoder.sv
// pcc_vote_encoder: thresholds a frame of feature samples into pos/neg vote vectors behind a valid/ready handshake.
// Define PCC_ENC_DECISION_EN to add the registered popcount(pos) >= popcount(neg) decision output.
module pcc_vote_encoder
  import pcc_enc_pkg::*;
#(
  parameter int N_POS  = N_POS_D,
  parameter int N_NEG  = N_NEG_D,
  parameter int FEAT_W = FEAT_W_D,
  localparam int NT = N_POS + N_NEG,
  localparam int IW = $clog2(NT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [FEAT_W-1:0] cfg_thr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_POS-1:0]  m_pos,
  output logic [N_NEG-1:0]  m_neg,
  output logic              m_decision,
  output logic              frame_err
);
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NT-1:0]     votes_q, votes_d;
  logic              m_valid_q, m_valid_d;
  logic [N_POS-1:0]  pos_q, pos_d;
  logic [N_NEG-1:0]  neg_q, neg_d;
  logic              err_q, err_d;
  logic [FEAT_W-1:0] thr_q [NT];
  logic              acc;
  assign s_ready   = (state_q == COLLECT) && !rst;
  assign acc       = s_valid && s_ready;
  assign m_valid   = m_valid_q;
  assign m_pos     = pos_q;
  assign m_neg     = neg_q;
  assign frame_err = err_q;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    votes_d   = votes_q;
    m_valid_d = m_valid_q;
    pos_d     = pos_q;
    neg_d     = neg_q;
    err_d     = err_q;
    if (acc) begin
      votes_d[idx_q] = s_data >= thr_q[idx_q];
      idx_d = idx_q + IW'(1);
      // s_last must coincide exactly with the final index, otherwise the frame is dropped
      if (s_last != (idx_q == IW'(NT - 1))) begin
        err_d = 1'b1;
        idx_d = '0;
      end else if (s_last) begin
        pos_d     = votes_d[N_POS-1:0];
        neg_d     = votes_d[NT-1:N_POS];
        m_valid_d = 1'b1;
        idx_d     = '0;
        state_d   = HOLD;
      end
    end
    if (state_q == HOLD && m_ready) begin
      m_valid_d = 1'b0;
      state_d   = COLLECT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      votes_q   <= '0;
      m_valid_q <= 1'b0;
      pos_q     <= '0;
      neg_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NT; i++) thr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      votes_q   <= votes_d;
      m_valid_q <= m_valid_d;
      pos_q     <= pos_d;
      neg_q     <= neg_d;
      err_q     <= err_d;
      if (cfg_we && int'(cfg_idx) < NT) thr_q[cfg_idx] <= cfg_thr;
    end
  end
`ifdef PCC_ENC_DECISION_EN
  localparam int PW = cnt_w(N_POS);
  localparam int NW = cnt_w(N_NEG);
  localparam int CW = (PW > NW) ? PW : NW;
  logic [PW-1:0] pc_pos;
  logic [NW-1:0] pc_neg;
  logic          dec_q, dec_d;
  pcc_popcount #(.W(N_POS)) u_pc_pos (.bits(votes_d[N_POS-1:0]), .cnt(pc_pos));
  pcc_popcount #(.W(N_NEG)) u_pc_neg (.bits(votes_d[NT-1:N_POS]), .cnt(pc_neg));
  always_comb dec_d = (state_q == COLLECT && state_d == HOLD) ? (CW'(pc_pos) >= CW'(pc_neg)) : dec_q;
  always_ff @(posedge clk) dec_q <= rst ? 1'b0 : dec_d;
  assign m_decision = dec_q;
`else
  assign m_decision = 1'b0;
`endif
endmodule

// File: tb/tb_pcc_vote_encoder.sv
// tb_pcc_vote_encoder: directed and randomized frames checked against a sample-level vote model.
module tb_pcc_vote_encoder;
  logic       clk = 0, rst = 1, cfg_we = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [2:0] cfg_idx = 0;
  logic [7:0] cfg_thr = 0, s_data = 0;
  logic       s_ready, m_valid, m_decision, frame_err;
  logic [1:0] m_pos;
  logic [5:0] m_neg;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] thr_m [8];
  logic [7:0] exp_v;
  int         m_idx;
  logic [1:0] e_pos;
  logic [5:0] e_neg;
  logic       e_err;

  pcc_vote_encoder dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_thr(cfg_thr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_pos(m_pos), .m_neg(m_neg),
    .m_decision(m_decision), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic e_dec();
`ifdef PCC_ENC_DECISION_EN
    return $countones(e_pos) >= $countones(e_neg);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset(input int n);
    rst = 1; s_valid = 0; s_last = 0; cfg_we = 0; m_ready = 0;
    tick;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_pos", m_pos, 0);
    check("rst_m_neg", m_neg, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_decision", m_decision, 0);
    repeat (n - 1) tick;
    rst = 0;
    for (int i = 0; i < 8; i++) thr_m[i] = 8'h00;
    m_idx = 0; e_err = 0; exp_v = '0;
    #1;
    check("post_rst_s_ready", s_ready, 1);
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [7:0] thr);
    cfg_we = 1; cfg_idx = idx; cfg_thr = thr;
    tick;
    cfg_we = 0;
    thr_m[idx] = thr;
  endtask

  // A cfg write presented with the sample takes effect only after that sample's vote
  task automatic send(input logic [7:0] d, input logic last);
    int w = 0;
    s_valid = 1; s_data = d; s_last = last;
    while (!s_ready && w < 20) begin tick; w++; end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    exp_v[m_idx] = d >= thr_m[m_idx];
    if (last != (m_idx == 7)) begin
      e_err = 1; m_idx = 0;
    end else if (last) begin
      e_pos = exp_v[1:0]; e_neg = exp_v[7:2]; m_idx = 0;
    end else m_idx++;
    if (cfg_we) thr_m[cfg_idx] = cfg_thr;
    tick;
    s_valid = 0; s_last = 0; cfg_we = 0;
  endtask

  task automatic send_frame(input logic [7:0] d [8], input int last_at);
    for (int i = 0; i <= last_at; i++) send(d[i], i == last_at);
  endtask

  task automatic check_out(input string tag);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_pos"}, m_pos, e_pos);
    check({tag, "_neg"}, m_neg, e_neg);
    check({tag, "_dec"}, m_decision, e_dec());
    check({tag, "_err"}, frame_err, e_err);
  endtask

  task automatic handshake(input string tag, input int delay, input logic poke);
    for (int i = 0; i < delay; i++) begin
      s_valid = poke; s_data = 8'hFF; s_last = poke;
      tick;
      check({tag, "_hold_valid"}, m_valid, 1);
      check({tag, "_hold_pos"}, m_pos, e_pos);
      check({tag, "_hold_neg"}, m_neg, e_neg);
      check({tag, "_hold_s_ready"}, s_ready, 0);
    end
    s_valid = 0; s_last = 0;
    m_ready = 1;
    tick;
    m_ready = 0;
    check({tag, "_done_valid"}, m_valid, 0);
    check({tag, "_done_s_ready"}, s_ready, 1);
  endtask

  initial begin
    logic [7:0] fr [8];
    logic [7:0] fc [8];
    fr = '{8'h90, 8'h10, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h81, 8'h01};
    do_reset(3);
    for (int i = 0; i < 8; i++) cfg(3'(i), 8'h80);
    send_frame(fr, 6);
    send(fr[7], 1'b0);
    tick;
    check("err_unterminated", frame_err, 1);
    do_reset(2);
    for (int i = 0; i < 8; i++) cfg(3'(i), 8'h80);
    send_frame(fr, 7);
    check_out("thr80");
    check("thr80_pos_lit", m_pos, 2'b01);
    check("thr80_neg_lit", m_neg, 6'b010101);
    handshake("thr80", 5, 1'b1);
    send_frame(fr, 7);
    check_out("after_hold");
    handshake("after_hold", 0, 1'b0);
    send_frame(fr, 4);
    repeat (3) begin
      tick;
      check("short_no_valid", m_valid, 0);
      check("short_err", frame_err, 1);
    end
    send_frame(fr, 7);
    check_out("after_err");
    handshake("after_err", 1, 1'b0);
    for (int i = 0; i < 8; i++) cfg(3'(i), 8'h00);
    fc = '{8'h12, 8'h00, 8'h34, 8'hFE, 8'h56, 8'h00, 8'h78, 8'h9A};
    for (int i = 0; i < 3; i++) send(fc[i], 1'b0);
    cfg_we = 1; cfg_idx = 3; cfg_thr = 8'hFF;
    send(fc[3], 1'b0);
    for (int i = 4; i < 8; i++) send(fc[i], i == 7);
    check_out("coll_old");
    check("coll_old_vote3", m_neg[1], 1);
    handshake("coll_old", 0, 1'b0);
    send_frame(fc, 7);
    check_out("coll_new");
    check("coll_new_vote3", m_neg[1], 0);
    handshake("coll_new", 0, 1'b0);
    for (int i = 0; i < 4; i++) send(fr[i], 1'b0);
    do_reset(2);
    send_frame(fr, 7);
    check_out("rst_mid");
    check("rst_mid_pos_lit", m_pos, 2'b11);
    check("rst_mid_neg_lit", m_neg, 6'h3F);
    do_reset(2);
    check("rst_hold_valid", m_valid, 0);
    send_frame(fc, 7);
    check_out("rst_hold");
    handshake("rst_hold", 0, 1'b0);
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) cfg(3'($urandom_range(0, 7)), 8'($urandom));
      for (int i = 0; i < 8; i++) fr[i] = 8'($urandom);
      send_frame(fr, 7);
      check_out("rand");
      handshake("rand", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
